// File: rtl/spi_pkg.sv
// Shared types and idle levels for the frame-level SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRE_HI   = 3'd1,
    PRE_LO   = 3'd2,
    SHIFT_LO = 3'd3,
    SHIFT_HI = 3'd4,
    LATCH    = 3'd5
  } spi_state_e;

  localparam logic SCLK_IDLE = 1'b0;
  localparam logic LOAD_IDLE = 1'b1;

endpackage

// File: rtl/spi_half_tick.sv
// Half-period timer: one-cycle tick after HALF_DIV cycles, restartable at phase changes.
module spi_half_tick #(
  parameter int unsigned HALF_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick_c
);

  localparam int unsigned CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_c = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || tick_c) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master.sv
// SPI frame master: preload pulse, WIDTH MSB-first data pulses, then a load edge to latch the slave.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH    = 13,
  parameter int unsigned HALF_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             sclk,
  output logic             mosi,
  output logic             load,
  input  logic             miso
);

  localparam int unsigned BIT_W = $clog2(WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  spi_state_e       state_q, state_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             sclk_q, sclk_d;
  logic             load_q, load_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick_c;
  logic             restart_c;

  assign restart_c = (state_q == IDLE) || (state_d != state_q);

  spi_half_tick #(.HALF_DIV(HALF_DIV)) u_half_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart_c),
    .tick_c  (tick_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start)  state_d = PRE_HI;
      PRE_HI:   if (tick_c) state_d = PRE_LO;
      PRE_LO:   if (tick_c) state_d = SHIFT_LO;
      SHIFT_LO: if (tick_c) state_d = SHIFT_HI;
      SHIFT_HI: if (tick_c) state_d = (bit_cnt_q == LAST_BIT) ? LATCH : SHIFT_LO;
      LATCH:    if (tick_c) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Pin levels follow the upcoming state; mosi only moves one cycle into a low phase.
  always_comb begin
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    mosi_d    = mosi_q;
    sclk_d    = (state_d == PRE_HI || state_d == SHIFT_HI) ? ~SCLK_IDLE : SCLK_IDLE;
    load_d    = (state_d == IDLE || state_d == PRE_HI || state_d == PRE_LO) ? LOAD_IDLE : ~LOAD_IDLE;
    busy_d    = (state_d != IDLE);
    done_d    = (state_q == LATCH) && (state_d == IDLE);

    if (state_q == IDLE && state_d == PRE_HI) begin
      tx_sr_d   = tx_data;
      rx_sr_d   = '0;
      bit_cnt_d = '0;
      mosi_d    = 1'b0;
    end
    if (state_q == SHIFT_LO) begin
      mosi_d = tx_sr_q[WIDTH-1];
      if (state_d == SHIFT_HI) rx_sr_d = {rx_sr_q[WIDTH-2:0], miso};
    end
    if (state_q == SHIFT_HI && state_d != SHIFT_HI) begin
      tx_sr_d   = tx_sr_q << 1;
      bit_cnt_d = bit_cnt_q + BIT_W'(1);
    end
    if (state_q == LATCH) mosi_d = 1'b0;
    if (done_d) rx_data_d = rx_sr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= SCLK_IDLE;
      load_q    <= LOAD_IDLE;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      load_q    <= load_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign sclk    = sclk_q;
  assign load    = load_q;
  assign mosi    = mosi_q;

endmodule
